// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Time-multiplexed driver for an 8-digit, 7-segment display. It scans the
// digits 7 down to 0 through an external 8:1 nibble mux. On each scan tick it
// decodes the mux nibble to active-low segments and drives the active-low
// anodes. It supports a per-digit enable, a decimal-point mask and optional
// leading-zero blanking.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   hex_in   in   [3:0] nibble from the mux for the current sel
//   en_mask  in   [7:0] bit i = 1 enables digit i
//   dp_mask  in   [7:0] bit i = 1 lights the decimal point on digit i
//   blank_lz in   1 = suppress leading zeros
//   sel      out  [2:0] digit index to the mux select
//   an       out  [7:0] anodes, active-low
//   seg      out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp       out  decimal point, active-low
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hex_in,
  input  logic [7:0] en_mask,
  input  logic [7:0] dp_mask,
  input  logic       blank_lz,
  output logic [2:0] sel,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [2:0]    sel_reg;
  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;
  logic          nz_reg;

  logic          tick;
  logic [7:0]    digit_onehot;
  logic          nz_eff;
  logic          hex_zero;
  logic          blanked;
  logic          lit;
  logic [6:0]    seg_dec;
  logic [7:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic          nz_next;
  logic [2:0]    sel_next;

  assign tick = (cnt_reg == CNT_MAX);

  // One-hot decode of the current digit index.
  for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
    assign digit_onehot[gi] = (sel_reg == 3'(gi));
  end

  // Hex to active-low segment decode, {g,f,e,d,c,b,a}.
  always_comb begin
    seg_dec = 7'h7F;
    case (hex_in)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_comb begin
    // Digit 7 starts a new frame, so the "non-zero seen" flag restarts there.
    nz_eff   = (sel_reg == 3'd7) ? 1'b0 : nz_reg;
    hex_zero = (hex_in == 4'h0);
    // Digit 0 is never blanked, so an all-zero value still shows "0".
    blanked  = blank_lz & ~nz_eff & hex_zero & (sel_reg != 3'd0);
    lit      = en_mask[sel_reg] & ~blanked;
    an_next  = lit ? ~digit_onehot : 8'hFF;
    seg_next = lit ? seg_dec : 7'h7F;
    dp_next  = lit ? ~dp_mask[sel_reg] : 1'b1;
    // A disabled digit shows nothing, so it must not end the leading-zero run.
    nz_next  = nz_eff | (en_mask[sel_reg] & ~hex_zero);
    sel_next = sel_reg - 3'd1;  // 0 wraps naturally to 7
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
      sel_reg <= 3'd7;
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
      nz_reg  <= 1'b0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        sel_reg <= sel_next;
        an_reg  <= an_next;
        seg_reg <= seg_next;
        dp_reg  <= dp_next;
        nz_reg  <= nz_next;
      end
    end
  end

  assign sel = sel_reg;
  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
// Self-checking bench for seg_scan_ctrl with TICK_DIV = 4. The bench models
// the 8:1 nibble mux from a 32-bit word. Each scenario pushes the expected
// per-tick display state to a queue. The scan loop pops one entry per tick
// and compares it. Between ticks the outputs must hold.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] hex_in;
  logic [7:0] en_mask = 8'hFF;
  logic [7:0] dp_mask = 8'h00;
  logic       blank_lz = 1'b0;
  logic [2:0] sel;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  logic [31:0] word = 32'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  always #5 clk = ~clk;

  // Bench model of the external nibble mux.
  assign hex_in = word[{sel, 2'b00} +: 4];

  seg_scan_ctrl #(.TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .hex_in(hex_in), .en_mask(en_mask),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .sel(sel), .an(an),
    .seg(seg), .dp(dp)
  );

  function automatic logic [6:0] dec(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Push the expected state after each of the 8 ticks of one frame.
  task automatic push_frame(input logic [31:0] w, input logic [7:0] en,
                            input logic [7:0] dpm, input logic blz);
    logic nz = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      logic [3:0] h;
      logic nze, blank, lit;
      exp_t e;
      h     = w[i*4 +: 4];
      nze   = (i == 7) ? 1'b0 : nz;
      blank = blz && !nze && (h == 4'h0) && (i != 0);
      lit   = en[i] && !blank;
      e.an  = lit ? ~(8'h01 << i) : 8'hFF;
      e.seg = lit ? dec(h) : 7'h7F;
      e.dp  = lit ? ~dpm[i] : 1'b1;
      e.sel = (i == 0) ? 3'd7 : 3'(i - 1);
      exp_q.push_back(e);
      nz = nze | (en[i] && (h != 4'h0));
    end
  endtask

  task automatic cmp_state(input string name, input exp_t e);
    checks++;
    if (an !== e.an || seg !== e.seg || dp !== e.dp || sel !== e.sel) begin
      errors++;
      $display("FAIL %s: got an=%h seg=%h dp=%b sel=%0d, expected an=%h seg=%h dp=%b sel=%0d",
               name, an, seg, dp, sel, e.an, e.seg, e.dp, e.sel);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur.an = 8'hFF; cur.seg = 7'h7F; cur.dp = 1'b1; cur.sel = 3'd7;
  endtask

  // Run n ticks. Check hold on intermediate cycles and pop at each tick.
  task automatic run_ticks(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < TICK_DIV - 1; c++) begin
        @(negedge clk);
        cmp_state({name, "_hold"}, cur);
      end
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s: scoreboard empty at tick %0d", name, k);
      end else begin
        cur = exp_q.pop_front();
        cmp_state(name, cur);
        $display("tick %s #%0d: an=%h seg=%h dp=%b sel=%0d", name, k, an, seg, dp, sel);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || sel !== 3'd7) begin
      errors++;
      $display("FAIL reset_state: got an=%h seg=%h dp=%b sel=%0d, expected FF/7F/1/7", an, seg, dp, sel);
    end
    word = 32'h89ABCDEF; en_mask = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    push_frame(word, en_mask, dp_mask, blank_lz);
    run_ticks("first_tick", 1);
    checks++;
    if (an !== 8'h7F || sel !== 3'd6) begin
      errors++;
      $display("FAIL first_tick_const: got an=%h sel=%0d, expected an=7F sel=6", an, sel);
    end
    exp_q.delete();
  endtask

  task automatic test_decode();
    word = 32'h89ABCDEF; en_mask = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    push_frame(word, en_mask, dp_mask, blank_lz);
    push_frame(word, en_mask, dp_mask, blank_lz);
    run_ticks("decode", 16);
  endtask

  task automatic test_back_to_back();
    word = 32'h00000305; en_mask = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b1;
    do_reset();
    push_frame(word, en_mask, dp_mask, blank_lz);
    push_frame(word, en_mask, dp_mask, blank_lz);
    run_ticks("lz_305", 15);
    checks++;
    if (an !== 8'hFD || seg !== 7'h40) begin
      errors++;
      $display("FAIL lz_305_digit1: got an=%h seg=%h, expected FD/40", an, seg);
    end
    run_ticks("lz_305", 1);
  endtask

  task automatic test_all_zero();
    word = 32'h0; en_mask = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b1;
    do_reset();
    push_frame(word, en_mask, dp_mask, blank_lz);
    run_ticks("all_zero", 8);
    checks++;
    if (an !== 8'hFE || seg !== 7'h40) begin
      errors++;
      $display("FAIL all_zero_digit0: got an=%h seg=%h, expected FE/40", an, seg);
    end
  endtask

  task automatic test_masks();
    word = 32'h12345678; en_mask = 8'h0F; dp_mask = 8'h04; blank_lz = 1'b1;
    do_reset();
    push_frame(word, en_mask, dp_mask, blank_lz);
    run_ticks("masks", 6);
    checks++;
    if (an !== 8'hFB || dp !== 1'b0 || seg !== 7'h02) begin
      errors++;
      $display("FAIL masks_dp: got an=%h seg=%h dp=%b, expected FB/02/0", an, seg, dp);
    end
    run_ticks("masks", 2);
  endtask

  task automatic test_midslot_reset();
    word = 32'h12345678; en_mask = 8'hFF; dp_mask = 8'h00; blank_lz = 1'b0;
    do_reset();
    push_frame(word, en_mask, dp_mask, blank_lz);
    run_ticks("pre_rst", 5);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || sel !== 3'd7) begin
      errors++;
      $display("FAIL midslot_reset: got an=%h seg=%h dp=%b sel=%0d, expected FF/7F/1/7", an, seg, dp, sel);
    end
    @(negedge clk);
    rst = 1'b0;
    cur.an = 8'hFF; cur.seg = 7'h7F; cur.dp = 1'b1; cur.sel = 3'd7;
    push_frame(word, en_mask, dp_mask, blank_lz);
    run_ticks("post_rst", 2);
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_all_zero();
    test_masks();
    test_midslot_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed driver for the 8-digit 7-segment display on the board.
- Generates the 3-bit digit select that feeds the 8:1 nibble mux (32-bit word -> 4-bit digit).
- Consumes the mux's 4-bit output, decodes it to active-low segments and drives the active-low anodes.
- Includes a scan prescaler, per-digit enable, decimal-point mask and optional leading-zero blanking.

Parameters:
- TICK_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- hex_in  input  4  nibble returned by the mux for the current sel.
- en_mask  input  8  bit i=1 enables digit i.
- dp_mask  input  8  bit i=1 lights the decimal point on digit i.
- blank_lz  input  1  1 = suppress leading zeros.
- sel  output  3  digit index to the mux select.
- an  output  8  anodes, active-low, one-hot-low when lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (async, immediate, also mid-scan): cnt=0, sel=7, an=8'hFF, seg=7'h7F, dp=1, nz=0.
- Prescaler: cnt counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where cnt==TICK_DIV-1, so the first tick occurs at cycle TICK_DIV-1 after reset release.
- Scan order is 7,6,...,0, then wraps to 7. sel is registered. hex_in is taken combinationally from the mux in the same cycle.
- On tick, with i=sel:
  - The digit is lit if en_mask[i]=1 and not blanked.
  - Lit digit: an <= ~(1<<i), seg <= decode(hex_in), dp <= ~dp_mask[i].
  - Dark digit: an <= 8'hFF, seg <= 7'h7F, dp <= 1.
  - sel <= i-1, wrapping 0 -> 7.
- Between ticks, an/seg/dp/sel hold their values. an, seg and dp always change together in the same cycle.
- Leading-zero blanking, evaluated on tick with i=sel:
  - nz_eff = (i==7) ? 0 : nz, i.e. the flag is cleared at frame start.
  - The digit is blanked iff blank_lz=1 and nz_eff=0 and hex_in==0 and i!=0. Digit 0 is never blanked, so an all-zero value still shows "0".
  - nz <= nz_eff | (en_mask[i] & hex_in!=0). Disabled digits do not set nz.
- Input timing: en_mask, dp_mask and blank_lz are sampled only on tick. A change affects the next digit latched, never the current display mid-slot.
- Decode table (hex -> seg):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E

Test Plan:
- Reset release, TICK_DIV=4 -> an=FF, seg=7F, dp=1 until the first tick at cycle 3. Then an=7F (digit 7) and sel=6. Subsequent ticks every 4 cycles, sel 6,5,...,0,7.
- Mux word 32'h89ABCDEF, en_mask=FF, blank_lz=0 -> per tick, (an,seg) = (7F,00), (BF,10), (DF,08), (EF,03), (F7,46), (FB,21), (FD,06), (FE,0E); the sequence repeats.
- Word 32'h00000305, blank_lz=1 -> digits 7..3 dark (an=FF). Then digit 2 seg=30, digit 1 seg=40 (not blanked, nz set), digit 0 seg=12. Next frame repeats identically, confirming nz is cleared at digit 7.
- Word 0, blank_lz=1 -> digits 7..1 dark, digit 0 an=FE, seg=40.
- en_mask=0x0F, dp_mask=0x04, word 32'h12345678, blank_lz=1 -> digits 7..4 dark and do not set nz. Digits 3..0 show 5,6,7,8; dp=0 only while an=FB.
- Assert rst mid-slot while digit 3 is lit -> same cycle an=FF, seg=7F, dp=1. After release, sel=7 and the first tick occurs 3 cycles later.
